// File: rtl/mem_stage_pkg.sv
// Uop bundle types shared by the execute, memory and writeback stages.
// Memory-stage state, byte-enable constants and access-size helper.
package Uop;

    typedef enum logic [2:0] {
        EX_NONE      = 3'd0,
        EX_ILLEGAL   = 3'd1,
        EX_MEM_ALIGN = 3'd2,
        EX_ECALL     = 3'd3,
        EX_BREAK     = 3'd4
    } ex_t;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_RSV = 2'd3
    } mem_op_sz_t;

    typedef struct packed {
        ex_t        ex;
        logic       exValid;
        logic [4:0] rd;
        logic [31:0] rdVal;
        logic       flagsValid;
        logic [3:0] flags;
        logic       isLd;
        logic       isSt;
        mem_op_sz_t sz;
        logic       signExtend;
        logic [31:0] rs2Val;
    } execute_t;

    typedef struct packed {
        ex_t        ex;
        logic       exValid;
        logic [4:0] rd;
        logic [31:0] rdVal;
        logic       flagsValid;
        logic [3:0] flags;
        logic       memNack;
    } memory_t;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUS  = 1'b1
    } mem_state_t;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_LO_H = 4'b0011;
    localparam logic [3:0] BE_HI_H = 4'b1100;
    localparam logic [3:0] BE_ALL  = 4'b1111;

    // Reserved size encoding behaves as a word access.
    function automatic mem_op_sz_t memSize(input mem_op_sz_t sz);
        return (sz == SZ_RSV) ? SZ_W : sz;
    endfunction

endpackage

// File: rtl/mem_stage_lane_align.sv
// Byte-lane steering for the data bus: store enables/replication
// and load lane extraction with sign or zero extension.
module mem_lane_align
    import Uop::*;
(
    input  logic [1:0]  stAddr,
    input  mem_op_sz_t  stSz,
    input  logic [31:0] stData,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [1:0]  ldAddr,
    input  mem_op_sz_t  ldSz,
    input  logic        ldSigned,
    input  logic [31:0] rdata,
    output logic [31:0] ldVal
);

    logic [7:0]  ldByte;
    logic [15:0] ldHalf;

    // Store side: enables and lane-replicated write data.
    always_comb begin
        be    = BE_ALL;
        wdata = stData;
        unique case (1'b1)
            stSz == SZ_B: begin
                be    = BE_B0 << stAddr;
                wdata = {4{stData[7:0]}};
            end
            stSz == SZ_H: begin
                be    = stAddr[1] ? BE_HI_H : BE_LO_H;
                wdata = {2{stData[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed lane and extend it.
    always_comb begin
        ldByte = rdata[{ldAddr, 3'b000} +: 8];
        ldHalf = ldAddr[1] ? rdata[31:16] : rdata[15:0];
        ldVal  = rdata;
        unique case (1'b1)
            ldSz == SZ_B: ldVal = {{24{ldSigned & ldByte[7]}}, ldByte};
            ldSz == SZ_H: ldVal = {{16{ldSigned & ldHalf[15]}}, ldHalf};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: single-outstanding loads/stores,
// alignment exceptions, bus error/timeout reporting, pass-through.
module mem_stage
    import Uop::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        inValid,
    output logic        inReady,
    input  execute_t    inUop,
    output logic        outValid,
    input  logic        outReady,
    output memory_t     outUop,
    output logic        busReq,
    output logic        busWe,
    output logic [29:0] busAddr,
    output logic [3:0]  busBe,
    output logic [31:0] busWData,
    input  logic [31:0] busRData,
    input  logic        busAck,
    input  logic        busNack
);

    mem_state_t     state;
    mem_state_t     stateNext;
    logic           kill;
    logic [TO_W-1:0] toCnt;
    memory_t        pend;
    logic           pendSt;
    mem_op_sz_t     pendSz;
    logic           pendSx;

    mem_op_sz_t     inSz;
    logic           isMem;
    logic           misAlign;
    logic           accept;
    logic           goBus;
    logic           goPass;
    logic           toHit;
    logic           resp;
    logic           isNack;
    logic [3:0]     stBe;
    logic [31:0]    stWData;
    logic [31:0]    ldVal;
    memory_t        passOut;
    memory_t        memOut;

    assign inSz    = memSize(inUop.sz);
    assign isMem   = inUop.isLd | inUop.isSt;
    assign inReady = !flush && (state == MEM_IDLE)
                     && (!outValid || outReady);
    assign accept  = inValid && inReady;
    assign goBus   = accept && isMem && !inUop.exValid && !misAlign;
    assign goPass  = accept && !goBus;
    assign toHit   = (TIMEOUT != 0) && (state == MEM_BUS)
                     && (toCnt == TO_W'(TIMEOUT - 1))
                     && !busAck && !busNack;
    assign resp    = (state == MEM_BUS) && (busAck || busNack || toHit);
    assign isNack  = busNack || toHit;

    // Alignment check on the ALU byte address.
    always_comb begin
        misAlign = 1'b0;
        unique case (1'b1)
            inSz == SZ_B: misAlign = 1'b0;
            inSz == SZ_H: misAlign = inUop.rdVal[0];
            default:      misAlign = |inUop.rdVal[1:0];
        endcase
    end

    mem_lane_align uLane (
        .stAddr  (inUop.rdVal[1:0]),
        .stSz    (inSz),
        .stData  (inUop.rs2Val),
        .be      (stBe),
        .wdata   (stWData),
        .ldAddr  (pend.rdVal[1:0]),
        .ldSz    (pendSz),
        .ldSigned(pendSx),
        .rdata   (busRData),
        .ldVal   (ldVal)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MEM_IDLE;
        else        state <= stateNext;
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        unique case (state)
            MEM_IDLE: if (goBus) stateNext = MEM_BUS;
            MEM_BUS:  if (resp)  stateNext = MEM_IDLE;
            default:  stateNext = MEM_IDLE;
        endcase
    end

    // FSM outputs: request is held for the whole bus phase.
    always_comb begin
        busReq = (state == MEM_BUS);
    end

    // Timeout counter counts bus cycles with no response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          toCnt <= '0;
        else if ((state == MEM_BUS) && !resp) toCnt <= toCnt + 1'b1;
        else                                 toCnt <= '0;
    end

    // Kill flag remembers a flush seen while the bus is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   kill <= 1'b0;
        else if (state != MEM_BUS)    kill <= 1'b0;
        else if (resp)                kill <= 1'b0;
        else if (flush)               kill <= 1'b1;
    end

    // Bus command and pending uop captured at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busWe    <= 1'b0;
            busAddr  <= '0;
            busBe    <= BE_NONE;
            busWData <= '0;
            pend     <= '0;
            pendSt   <= 1'b0;
            pendSz   <= SZ_B;
            pendSx   <= 1'b0;
        end else if (goBus) begin
            busWe    <= inUop.isSt;
            busAddr  <= inUop.rdVal[31:2];
            busBe    <= stBe;
            busWData <= stWData;
            pend     <= passOut;
            pendSt   <= inUop.isSt;
            pendSz   <= inSz;
            pendSx   <= inUop.signExtend;
        end
    end

    // Result formatting for pass-through and bus completion.
    always_comb begin
        passOut.ex         = inUop.ex;
        passOut.exValid    = inUop.exValid;
        passOut.rd         = inUop.rd;
        passOut.rdVal      = inUop.rdVal;
        passOut.flagsValid = inUop.flagsValid;
        passOut.flags      = inUop.flags;
        passOut.memNack    = 1'b0;
        if (isMem && misAlign && !inUop.exValid) begin
            passOut.ex      = EX_MEM_ALIGN;
            passOut.exValid = 1'b1;
        end
        memOut         = pend;
        memOut.memNack = isNack;
        if (!isNack && !pendSt) memOut.rdVal = ldVal;
    end

    // Output register with valid/ready hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid <= 1'b0;
            outUop   <= '0;
        end else if (flush) begin
            outValid <= 1'b0;
        end else if (goPass || (resp && !kill)) begin
            outValid <= 1'b1;
            outUop   <= goPass ? passOut : memOut;
        end else if (outReady) begin
            outValid <= 1'b0;
        end
    end

endmodule
